// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: centisecond BCD stopwatch with start/stop, lap and clear buttons.
// The lap register and LAP state exist only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter bit HOLD_OVF = 1'b0
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic        tick_100hz,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [21:0] time_disp,
  output logic [1:0]  state,
  output logic        running,
  output logic        ovf
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
  state_t      r_state, w_ns;
  logic [21:0] r_cnt, w_cnt_nxt;
  logic        w_tick, w_roll, w_clr;
  logic        w_c0, w_c1, w_c2, w_c3, w_c4;
`ifdef STOPWATCH_LAP_EN
  logic [21:0] r_lap;
  logic        w_lap_ld;
`endif
  assign w_tick = tick_100hz && (r_state == RUN || r_state == LAP);
  assign w_c0   = r_cnt[3:0] == 4'd9;
  assign w_c1   = w_c0 && r_cnt[7:4] == 4'd9;
  assign w_c2   = w_c1 && r_cnt[11:8] == 4'd9;
  assign w_c3   = w_c2 && r_cnt[14:12] == 3'd5;
  assign w_c4   = w_c3 && r_cnt[18:15] == 4'd9;
  assign w_roll = w_tick && w_c4 && r_cnt[21:19] == 3'd5;
  assign state  = r_state;
  // each digit wraps when every lower digit carries; a saturating rollover leaves the count untouched
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_tick && !(w_roll && HOLD_OVF)) begin
      w_cnt_nxt[3:0]   = w_c0 ? 4'd0 : r_cnt[3:0] + 4'd1;
      w_cnt_nxt[7:4]   = w_c1 ? 4'd0 : w_c0 ? r_cnt[7:4] + 4'd1 : r_cnt[7:4];
      w_cnt_nxt[11:8]  = w_c2 ? 4'd0 : w_c1 ? r_cnt[11:8] + 4'd1 : r_cnt[11:8];
      w_cnt_nxt[14:12] = w_c3 ? 3'd0 : w_c2 ? r_cnt[14:12] + 3'd1 : r_cnt[14:12];
      w_cnt_nxt[18:15] = w_c4 ? 4'd0 : w_c3 ? r_cnt[18:15] + 4'd1 : r_cnt[18:15];
      w_cnt_nxt[21:19] = w_roll ? 3'd0 : w_c4 ? r_cnt[21:19] + 3'd1 : r_cnt[21:19];
    end
  end
  always_comb begin
    w_ns  = r_state;
    w_clr = 1'b0;
`ifdef STOPWATCH_LAP_EN
    w_lap_ld = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_clr = btn_clear;
        w_ns  = (!btn_clear && btn_start) ? RUN : IDLE;
      end
      RUN: begin
        w_ns = btn_start ? PAUSE : RUN;
`ifdef STOPWATCH_LAP_EN
        w_lap_ld = !btn_start && btn_lap;
        if (w_lap_ld) w_ns = LAP;
`endif
      end
      PAUSE: begin
        w_clr = btn_clear;
        w_ns  = btn_clear ? IDLE : btn_start ? RUN : PAUSE;
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        w_lap_ld = !btn_clear && !btn_start && btn_lap;
        w_ns     = btn_clear ? RUN : btn_start ? PAUSE : LAP;
      end
`endif
      default: w_ns = IDLE;
    endcase
    if (w_roll && HOLD_OVF) w_ns = PAUSE;
  end
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      time_disp <= '0;
      running   <= 1'b0;
      ovf       <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_lap     <= '0;
`endif
    end else begin
      r_state <= w_ns;
      running <= w_ns == RUN || w_ns == LAP;
      r_cnt   <= w_clr ? '0 : w_cnt_nxt;
      ovf     <= !w_clr && (ovf || w_roll);
`ifdef STOPWATCH_LAP_EN
      r_lap     <= w_clr ? '0 : w_lap_ld ? w_cnt_nxt : r_lap;
      time_disp <= r_state == LAP ? r_lap : r_cnt;
`else
      time_disp <= r_cnt;
`endif
    end
endmodule
